// File: rtl/tmr_hamming_scrub_reg.sv
// Triplicated Hamming(7,4) nibble register: votes and corrects the three copies every
// cycle and periodically rewrites all copies with the corrected codeword.
module tmr_hamming_scrub_reg #(
    parameter int SCRUB_PERIOD = 16,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [3:0]           wr_data,
    input  logic [6:0]           inj_mask_1,
    input  logic [6:0]           inj_mask_2,
    input  logic [6:0]           inj_mask_3,
    output logic [3:0]           rd_data,
    output logic                 err_flag,
    output logic                 mismatch,
    output logic                 scrub_active,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int CNT_W = (SCRUB_PERIOD > 2) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_SCRUB = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cycle_cnt;
    logic [6:0]       copy_1, copy_2, copy_3;
    logic [6:0]       voted;
    logic [2:0]       syndrome;
    logic [3:0]       decoded;
    logic [6:0]       corrected_cw;
    logic             copies_equal;
    logic             repair;
    logic [6:0]       next_1, next_2, next_3;

    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3],
                d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
    endfunction

    // Returns {s3,s2,s1}
    function automatic logic [2:0] hamming_syndrome(input logic [6:0] v);
        return {v[0] ^ v[1] ^ v[2] ^ v[3],
                v[0] ^ v[1] ^ v[4] ^ v[5],
                v[0] ^ v[2] ^ v[4] ^ v[6]};
    endfunction

    function automatic logic [3:0] hamming_decode(input logic [6:0] v, input logic [2:0] s);
        logic [6:0] c;
        c = v;
        case (s)
            3'b001:  c[6] = ~c[6];
            3'b010:  c[5] = ~c[5];
            3'b011:  c[4] = ~c[4];
            3'b100:  c[3] = ~c[3];
            3'b101:  c[2] = ~c[2];
            3'b110:  c[1] = ~c[1];
            3'b111:  c[0] = ~c[0];
            default: c = v;
        endcase
        return {c[4], c[2], c[1], c[0]};
    endfunction

    always_comb begin
        voted        = (copy_1 & copy_2) | (copy_1 & copy_3) | (copy_2 & copy_3);
        syndrome     = hamming_syndrome(voted);
        decoded      = hamming_decode(voted, syndrome);
        corrected_cw = hamming_encode(decoded);
        copies_equal = (copy_1 == copy_2) && (copy_2 == copy_3);
        repair       = (state == ST_SCRUB) && !wr_en &&
                       ((copy_1 != corrected_cw) || (copy_2 != corrected_cw) ||
                        (copy_3 != corrected_cw));
        next_1 = copy_1;
        next_2 = copy_2;
        next_3 = copy_3;
        if (wr_en) begin
            next_1 = hamming_encode(wr_data);
            next_2 = hamming_encode(wr_data);
            next_3 = hamming_encode(wr_data);
        end else if (repair) begin
            next_1 = corrected_cw;
            next_2 = corrected_cw;
            next_3 = corrected_cw;
        end
    end

    // Storage: upsets are applied on top of whichever next value was selected
    always_ff @(posedge clk) begin
        if (rst) begin
            copy_1 <= 7'h00;
            copy_2 <= 7'h00;
            copy_3 <= 7'h00;
        end else begin
            copy_1 <= next_1 ^ inj_mask_1;
            copy_2 <= next_2 ^ inj_mask_2;
            copy_3 <= next_3 ^ inj_mask_3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            cycle_cnt <= '0;
        end else if (state == ST_SCRUB) begin
            state <= ST_RUN;
        end else if (cycle_cnt == CNT_W'(SCRUB_PERIOD - 1)) begin
            state     <= ST_SCRUB;
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    // Read stage: reflects the copies held after the previous edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data   <= 4'h0;
            err_flag  <= 1'b0;
            mismatch  <= 1'b0;
            err_count <= '0;
        end else begin
            rd_data  <= decoded;
            err_flag <= (syndrome != 3'b000);
            mismatch <= !copies_equal;
            if (repair && (err_count != {ERR_CNT_W{1'b1}})) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign scrub_active = (state == ST_SCRUB);

endmodule

// File: tb/tb_tmr_hamming_scrub_reg.sv
// Bench for tmr_hamming_scrub_reg: directed scenarios plus random traffic, checked against
// a nearest-codeword reference model; a second instance uses a 2-bit repair counter.
module tb_tmr_hamming_scrub_reg;

    localparam int P = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [3:0] wr_data = 4'h0;
    logic [6:0] inj_mask_1 = 7'h00;
    logic [6:0] inj_mask_2 = 7'h00;
    logic [6:0] inj_mask_3 = 7'h00;

    logic [3:0] rd_data, rd_data_b;
    logic       err_flag, err_flag_b, mismatch, mismatch_b, scrub_active, scrub_active_b;
    logic [7:0] err_count;
    logic [1:0] err_count_b;

    tmr_hamming_scrub_reg #(.SCRUB_PERIOD(P), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .inj_mask_1(inj_mask_1), .inj_mask_2(inj_mask_2), .inj_mask_3(inj_mask_3),
        .rd_data(rd_data), .err_flag(err_flag), .mismatch(mismatch),
        .scrub_active(scrub_active), .err_count(err_count)
    );

    tmr_hamming_scrub_reg #(.SCRUB_PERIOD(P), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .inj_mask_1(inj_mask_1), .inj_mask_2(inj_mask_2), .inj_mask_3(inj_mask_3),
        .rd_data(rd_data_b), .err_flag(err_flag_b), .mismatch(mismatch_b),
        .scrub_active(scrub_active_b), .err_count(err_count_b)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [6:0] m_copy [3];
    int         m_n;
    logic [3:0] m_rd;
    logic       m_ef, m_mm;
    int         m_cnt8, m_cnt2;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    int exp_sat [5] = '{1, 2, 3, 3, 3};

    function automatic logic [6:0] enc(input logic [3:0] d);
        return {d[3] ^ d[2] ^ d[0], d[3] ^ d[1] ^ d[0], d[3],
                d[2] ^ d[1] ^ d[0], d[2], d[1], d[0]};
    endfunction

    function automatic logic [6:0] vote(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c);
        logic [6:0] r;
        for (int i = 0; i < 7; i++) begin
            r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
        end
        return r;
    endfunction

    // The code is perfect: every 7-bit word lies within distance 1 of exactly one codeword
    function automatic logic [3:0] dec(input logic [6:0] v);
        for (int d = 0; d < 16; d++) begin
            if ($countones(enc(4'(d)) ^ v) <= 1) return 4'(d);
        end
        return 4'h0;
    endfunction

    function automatic bit in_scrub(input int n);
        return (n % (P + 1)) == P;
    endfunction

    task automatic model_edge();
        logic [6:0] v, corr, nv [3];
        if (rst) begin
            for (int i = 0; i < 3; i++) m_copy[i] = 7'h00;
            m_n = 0; m_rd = 4'h0; m_ef = 1'b0; m_mm = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
        end else begin
            v    = vote(m_copy[0], m_copy[1], m_copy[2]);
            m_rd = dec(v);
            m_ef = (enc(dec(v)) != v);
            m_mm = !((m_copy[0] == m_copy[1]) && (m_copy[1] == m_copy[2]));
            corr = enc(dec(v));
            for (int i = 0; i < 3; i++) nv[i] = m_copy[i];
            if (wr_en) begin
                for (int i = 0; i < 3; i++) nv[i] = enc(wr_data);
            end else if (in_scrub(m_n) &&
                         (m_copy[0] != corr || m_copy[1] != corr || m_copy[2] != corr)) begin
                for (int i = 0; i < 3; i++) nv[i] = corr;
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            m_copy[0] = nv[0] ^ inj_mask_1;
            m_copy[1] = nv[1] ^ inj_mask_2;
            m_copy[2] = nv[2] ^ inj_mask_3;
            m_n++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("rd_data", 32'(rd_data), 32'(m_rd));
        check("err_flag", 32'(err_flag), 32'(m_ef));
        check("mismatch", 32'(mismatch), 32'(m_mm));
        check("scrub_active", 32'(scrub_active), 32'(in_scrub(m_n)));
        check("err_count", 32'(err_count), 32'(m_cnt8));
        check("rd_data_b", 32'(rd_data_b), 32'(m_rd));
        check("scrub_active_b", 32'(scrub_active_b), 32'(in_scrub(m_n)));
        check("err_count_b", 32'(err_count_b), 32'(m_cnt2));
    endtask

    task automatic step(input bit r, input bit w, input logic [3:0] d,
                        input logic [6:0] k1, input logic [6:0] k2, input logic [6:0] k3);
        @(negedge clk);
        rst = r; wr_en = w; wr_data = d;
        inj_mask_1 = k1; inj_mask_2 = k2; inj_mask_3 = k3;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 4'h0, 7'h00, 7'h00, 7'h00);
    endtask

    // Advances until the DUT should be sitting in SCRUB; the next step is the scrub edge
    task automatic wait_scrub();
        int k;
        k = 0;
        while (!in_scrub(m_n) && k < 2 * P + 4) begin
            idle(1);
            k++;
        end
        check("wait_scrub", 32'(scrub_active), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) m_copy[i] = 7'h00;
        m_n = 0; m_rd = 4'h0; m_ef = 1'b0; m_mm = 1'b0; m_cnt8 = 0; m_cnt2 = 0;

        // Reset with masks that must be ignored
        step(1'b1, 1'b0, 4'h0, 7'h7f, 7'h7f, 7'h7f);
        step(1'b1, 1'b0, 4'h0, 7'h7f, 7'h00, 7'h55);
        check("rst_rd", 32'(rd_data), 32'h0);
        check("rst_cnt", 32'(err_count), 32'h0);
        idle(40);
        check("idle_mm", 32'(mismatch), 32'h0);

        // Write 0xA and let scrubs pass
        step(1'b0, 1'b1, 4'hA, 7'h00, 7'h00, 7'h00);
        idle(2);
        check("wrA_rd", 32'(rd_data), 32'hA);
        idle(20);
        check("wrA_cnt", 32'(err_count), 32'h0);

        // Single-copy upset, repaired at the next scrub
        step(1'b0, 1'b0, 4'h0, 7'h01, 7'h00, 7'h00);
        idle(1);
        check("single_mm", 32'(mismatch), 32'h1);
        wait_scrub();
        idle(2);
        check("single_cnt", 32'(err_count), 32'h1);
        check("single_mm_clr", 32'(mismatch), 32'h0);

        // Two-copy upset: voted word is wrong, syndrome corrects it
        step(1'b0, 1'b0, 4'h0, 7'h10, 7'h10, 7'h00);
        idle(2);
        check("dbl_ef", 32'(err_flag), 32'h1);
        check("dbl_rd", 32'(rd_data), 32'hA);
        wait_scrub();
        idle(3);
        check("dbl_cnt", 32'(err_count), 32'h2);
        check("dbl_ef_clr", 32'(err_flag), 32'h0);

        // Write lands in the scrub cycle and wins over the repair
        step(1'b0, 1'b0, 4'h0, 7'h04, 7'h00, 7'h00);
        wait_scrub();
        step(1'b0, 1'b1, 4'h3, 7'h00, 7'h00, 7'h00);
        check("wrscrub_sa", 32'(scrub_active), 32'h0);
        idle(2);
        check("wrscrub_rd", 32'(rd_data), 32'h3);
        check("wrscrub_cnt", 32'(err_count), 32'h2);

        // Saturation of the 2-bit counter
        step(1'b1, 1'b0, 4'h0, 7'h00, 7'h00, 7'h00);
        step(1'b0, 1'b1, 4'h6, 7'h00, 7'h00, 7'h00);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 4'h0, 7'(1 << $urandom_range(6, 0)), 7'h00, 7'h00);
            wait_scrub();
            idle(1);
            check("sat_cnt_b", 32'(err_count_b), 32'(exp_sat[i]));
        end

        // Reset during a scrub with a repair pending
        step(1'b0, 1'b0, 4'h0, 7'h00, 7'h20, 7'h00);
        wait_scrub();
        step(1'b1, 1'b0, 4'h0, 7'h7f, 7'h00, 7'h00);
        check("rstscrub_cnt", 32'(err_count), 32'h0);
        check("rstscrub_cnt_b", 32'(err_count_b), 32'h0);
        idle(2);
        check("rstscrub_rd", 32'(rd_data), 32'h0);
        check("rstscrub_mm", 32'(mismatch), 32'h0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            logic [6:0] k [3];
            for (int j = 0; j < 3; j++) begin
                k[j] = 7'h00;
                if ($urandom_range(9, 0) == 0) begin
                    k[j] = ($urandom_range(3, 0) == 0) ? 7'($urandom) : 7'(1 << $urandom_range(6, 0));
                end
            end
            step(($urandom_range(99, 0) == 0), ($urandom_range(7, 0) == 0), 4'($urandom),
                 k[0], k[1], k[2]);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
